sdp_ram_byte_en: RTL and testbench

Parametrised simple dual-port RAM on a single clock: one write port (A) with byte enables, one read port (B) with selectable read latency, read-valid flag and defined read-during-write behaviour. A built-in clear sequencer fills the array with a constant after reset. It serves as the coefficient and scratch store for the arithmetic datapaths, and it is the generalised replacement for the fixed-width, fixed-latency 32-bit buffers.

---
 rtl/sdp_ram_byte_en.sv | 188 ++++++++++++++++++
 tb/tb_sdp_ram_byte_en.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_ram_byte_en.sv
// Simple dual-port RAM with byte-lane writes, 1- or 2-cycle registered read,
// selectable read-during-write result and a post-reset clear sequencer.
module sdp_ram_byte_en #(
    parameter int                   MEM_WIDTH      = 32,
    parameter int                   MEM_DEPTH      = 1024,
    parameter int                   BYTE_W         = 8,
    parameter int                   READ_LATENCY   = 1,
    parameter int                   RDW_MODE       = 0,
    parameter int                   CLEAR_ON_RESET = 1,
    parameter logic [MEM_WIDTH-1:0] CLEAR_VALUE    = '0,
    localparam int                  NB             = MEM_WIDTH / BYTE_W,
    localparam int                  AW             = $clog2(MEM_DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 en_a,
    input  logic [NB-1:0]        write_en_a,
    input  logic [AW-1:0]        addr_a,
    input  logic [MEM_WIDTH-1:0] data_in_a,
    input  logic                 en_b,
    input  logic [AW-1:0]        addr_b,
    output logic [MEM_WIDTH-1:0] data_out_b,
    output logic                 valid_b,
    output logic                 init_busy
);

    if (MEM_WIDTH % BYTE_W != 0) begin : g_chk_width
        $error("MEM_WIDTH must be a multiple of BYTE_W");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_chk_latency
        $error("READ_LATENCY must be 1 or 2");
    end
    if (MEM_DEPTH < 2) begin : g_chk_depth
        $error("MEM_DEPTH must be at least 2");
    end

    typedef enum logic [1:0] {
        ST_RESET,
        ST_CLEAR,
        ST_IDLE
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);
    localparam logic [AW:0]   DEPTH_X   = (AW + 1)'(MEM_DEPTH);

    logic [MEM_WIDTH-1:0] r_mem [MEM_DEPTH];

    state_t               r_state;
    state_t               w_state_next;
    logic [AW-1:0]        r_cnt;
    logic [AW-1:0]        w_cnt_next;
    logic                 w_clr_we;
    logic                 w_busy;

    logic                 w_wr_ok;
    logic [NB-1:0]        w_lane_we;
    logic [AW-1:0]        w_waddr;
    logic [MEM_WIDTH-1:0] w_wdata;

    logic                 w_rd_acc;
    logic                 w_rd_in;
    logic [AW-1:0]        w_raddr;
    logic                 w_rdw_hit;
    logic [MEM_WIDTH-1:0] w_rd_merged;
    logic [MEM_WIDTH-1:0] w_rd_word;

    logic [MEM_WIDTH-1:0] r_dout;
    logic                 r_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RESET;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // The first edge after reset release already clears address 0, so the
    // whole fill takes exactly MEM_DEPTH edges.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_clr_we     = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            ST_RESET: begin
                if (CLEAR_ON_RESET != 0) begin
                    w_clr_we     = 1'b1;
                    w_busy       = 1'b1;
                    w_cnt_next   = AW'(1);
                    w_state_next = ST_CLEAR;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                w_clr_we = 1'b1;
                w_busy   = 1'b1;
                if (r_cnt == LAST_ADDR) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt + AW'(1);
                end
            end
            ST_IDLE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_RESET;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign init_busy = w_busy;

    assign w_wr_ok = en_a && !w_busy && ({1'b0, addr_a} < DEPTH_X);
    assign w_waddr = w_clr_we ? r_cnt : addr_a;
    assign w_wdata = w_clr_we ? CLEAR_VALUE : data_in_a;

    assign w_rd_acc  = en_b && !w_busy;
    assign w_rd_in   = ({1'b0, addr_b} < DEPTH_X);
    assign w_raddr   = w_rd_in ? addr_b : '0;
    assign w_rdw_hit = (RDW_MODE != 0) && w_wr_ok && (addr_a == addr_b);

    // Per-lane write strobe and bypass merge for a same-address write.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign w_lane_we[gi] = w_clr_we | (w_wr_ok & write_en_a[gi]);
        assign w_rd_merged[gi*BYTE_W +: BYTE_W] =
            (w_rdw_hit && write_en_a[gi]) ? data_in_a[gi*BYTE_W +: BYTE_W]
                                          : r_mem[w_raddr][gi*BYTE_W +: BYTE_W];
    end

    assign w_rd_word = w_rd_in ? w_rd_merged : '0;

    always_ff @(posedge clock) begin
        for (int i = 0; i < NB; i++) begin
            if (w_lane_we[i]) begin
                r_mem[w_waddr][i*BYTE_W +: BYTE_W] <= w_wdata[i*BYTE_W +: BYTE_W];
            end
        end
    end

    if (READ_LATENCY == 1) begin : g_rl1
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_dout  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_rd_acc;
                if (w_rd_acc) begin
                    r_dout <= w_rd_word;
                end
            end
        end
    end else begin : g_rl2
        logic [MEM_WIDTH-1:0] r_rd_word;
        logic                 r_rd_v1;

        // Array-side register carries no reset so it maps onto the RAM output.
        always_ff @(posedge clock) begin
            if (w_rd_acc) begin
                r_rd_word <= w_rd_word;
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_rd_v1 <= 1'b0;
                r_dout  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_rd_v1 <= w_rd_acc;
                r_valid <= r_rd_v1;
                if (r_rd_v1) begin
                    r_dout <= r_rd_word;
                end
            end
        end
    end

    assign data_out_b = r_dout;
    assign valid_b    = r_valid;

endmodule

// File: tb/tb_sdp_ram_byte_en.sv
// Directed bench: three RAM configurations share one stimulus stream; each
// task checks the instances relevant to its scenario.
module tb_sdp_ram_byte_en;

    logic        clock;
    logic        reset_n;
    logic        en_a;
    logic [3:0]  write_en_a;
    logic [3:0]  addr_a;
    logic [31:0] data_in_a;
    logic        en_b;
    logic [3:0]  addr_b;

    // d0: 16 deep, clear A5A5A5A5, latency 1, old-data
    // d1: 16 deep, clear 0, latency 2, bypass
    // d2: 12 deep, clear 0, latency 1, old-data
    logic [31:0] dout0, dout1, dout2;
    logic        valid0, valid1, valid2;
    logic        busy0, busy1, busy2;

    int n_checks = 0;
    int n_fail   = 0;

    sdp_ram_byte_en #(
        .MEM_WIDTH(32), .MEM_DEPTH(16), .BYTE_W(8), .READ_LATENCY(1),
        .RDW_MODE(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'hA5A5A5A5)
    ) u_d0 (
        .clock(clock), .reset_n(reset_n), .en_a(en_a), .write_en_a(write_en_a),
        .addr_a(addr_a), .data_in_a(data_in_a), .en_b(en_b), .addr_b(addr_b),
        .data_out_b(dout0), .valid_b(valid0), .init_busy(busy0)
    );

    sdp_ram_byte_en #(
        .MEM_WIDTH(32), .MEM_DEPTH(16), .BYTE_W(8), .READ_LATENCY(2),
        .RDW_MODE(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'h0)
    ) u_d1 (
        .clock(clock), .reset_n(reset_n), .en_a(en_a), .write_en_a(write_en_a),
        .addr_a(addr_a), .data_in_a(data_in_a), .en_b(en_b), .addr_b(addr_b),
        .data_out_b(dout1), .valid_b(valid1), .init_busy(busy1)
    );

    sdp_ram_byte_en #(
        .MEM_WIDTH(32), .MEM_DEPTH(12), .BYTE_W(8), .READ_LATENCY(1),
        .RDW_MODE(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'h0)
    ) u_d2 (
        .clock(clock), .reset_n(reset_n), .en_a(en_a), .write_en_a(write_en_a),
        .addr_a(addr_a), .data_in_a(data_in_a), .en_b(en_b), .addr_b(addr_b),
        .data_out_b(dout2), .valid_b(valid2), .init_busy(busy2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset();
        int f0, f1, f2;
        f0 = 0; f1 = 0; f2 = 0;
        reset_n = 1'b0; en_a = 1'b0; write_en_a = 4'h0; addr_a = 4'h0;
        data_in_a = 32'h0; en_b = 1'b0; addr_b = 4'h0;
        repeat (3) @(negedge clock);
        n_checks++; if (dout0 !== 32'h0) begin n_fail++; $display("FAIL reset_dout0: got %h expected %h", dout0, 32'h0); end
        n_checks++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid0: got %b expected 0", valid0); end
        n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL reset_busy0: got %b expected 1", busy0); end
        n_checks++; if (dout1 !== 32'h0) begin n_fail++; $display("FAIL reset_dout1: got %h expected %h", dout1, 32'h0); end
        n_checks++; if (valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_valid1: got %b expected 0", valid1); end
        n_checks++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL reset_busy2: got %b expected 1", busy2); end
        reset_n = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (!busy0 && f0 == 0) f0 = n;
            if (!busy1 && f1 == 0) f1 = n;
            if (!busy2 && f2 == 0) f2 = n;
        end
        n_checks++; if (f0 != 16) begin n_fail++; $display("FAIL clear_edges_d0: got %0d expected 16", f0); end
        n_checks++; if (f1 != 16) begin n_fail++; $display("FAIL clear_edges_d1: got %0d expected 16", f1); end
        n_checks++; if (f2 != 12) begin n_fail++; $display("FAIL clear_edges_d2: got %0d expected 12", f2); end
        $display("reset/clear: d0 %0d edges, d1 %0d edges, d2 %0d edges", f0, f1, f2);
    endtask

    task automatic test_clear_reads();
        for (int i = 0; i <= 16; i++) begin
            @(negedge clock);
            if (i > 0) begin
                n_checks++; if (valid0 !== 1'b1) begin n_fail++; $display("FAIL clear_read_valid addr %0d: got %b expected 1", i - 1, valid0); end
                n_checks++; if (dout0 !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL clear_read_data addr %0d: got %h expected a5a5a5a5", i - 1, dout0); end
                $display("clear read addr %0d -> %h valid %b", i - 1, dout0, valid0);
            end
            en_b   = (i < 16);
            addr_b = 4'(i);
        end
        en_b = 1'b0;
    endtask

    task automatic test_byte_write();
        @(negedge clock);
        en_a = 1'b1; write_en_a = 4'b1111; addr_a = 4'd3; data_in_a = 32'h3e96bb98;
        @(negedge clock);
        write_en_a = 4'b0001; data_in_a = 32'h00000011;
        @(negedge clock);
        en_a = 1'b0; en_b = 1'b1; addr_b = 4'd3;
        @(negedge clock);
        en_b = 1'b0;
        n_checks++; if (dout0 !== 32'h3e96bb11 || valid0 !== 1'b1) begin n_fail++; $display("FAIL byte_write_d0: got %h/%b expected 3e96bb11/1", dout0, valid0); end
        n_checks++; if (dout2 !== 32'h3e96bb11) begin n_fail++; $display("FAIL byte_write_d2: got %h expected 3e96bb11", dout2); end
        n_checks++; if (valid1 !== 1'b0) begin n_fail++; $display("FAIL byte_write_d1_early: got valid %b expected 0", valid1); end
        @(negedge clock);
        n_checks++; if (dout1 !== 32'h3e96bb11 || valid1 !== 1'b1) begin n_fail++; $display("FAIL byte_write_d1: got %h/%b expected 3e96bb11/1", dout1, valid1); end
        n_checks++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL byte_write_pulse_d0: got valid %b expected 0", valid0); end
        $display("byte write addr 3: d0 %h d1 %h d2 %h", dout0, dout1, dout2);
    endtask

    task automatic test_rdw();
        @(negedge clock);
        en_a = 1'b1; write_en_a = 4'b1111; addr_a = 4'd5; data_in_a = 32'h12345678;
        en_b = 1'b1; addr_b = 4'd5;
        @(negedge clock);
        n_checks++; if (dout2 !== 32'h0 || valid2 !== 1'b1) begin n_fail++; $display("FAIL rdw_old_d2: got %h/%b expected 00000000/1", dout2, valid2); end
        n_checks++; if (dout0 !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL rdw_old_d0: got %h expected a5a5a5a5", dout0); end
        write_en_a = 4'b0101; addr_a = 4'd6; data_in_a = 32'hDEADBEEF; addr_b = 4'd6;
        @(negedge clock);
        n_checks++; if (dout1 !== 32'h12345678 || valid1 !== 1'b1) begin n_fail++; $display("FAIL rdw_new_d1: got %h/%b expected 12345678/1", dout1, valid1); end
        n_checks++; if (dout0 !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL rdw_partial_old_d0: got %h expected a5a5a5a5", dout0); end
        n_checks++; if (dout2 !== 32'h0) begin n_fail++; $display("FAIL rdw_partial_old_d2: got %h expected 00000000", dout2); end
        en_a = 1'b0; addr_b = 4'd5;
        @(negedge clock);
        n_checks++; if (dout1 !== 32'h00AD00EF) begin n_fail++; $display("FAIL rdw_partial_new_d1: got %h expected 00ad00ef", dout1); end
        n_checks++; if (dout0 !== 32'h12345678) begin n_fail++; $display("FAIL wr_then_rd_d0: got %h expected 12345678", dout0); end
        addr_b = 4'd6;
        @(negedge clock);
        en_b = 1'b0;
        n_checks++; if (dout1 !== 32'h12345678) begin n_fail++; $display("FAIL wr_then_rd_d1: got %h expected 12345678", dout1); end
        n_checks++; if (dout0 !== 32'hA5ADA5EF) begin n_fail++; $display("FAIL lane_merge_d0: got %h expected a5ada5ef", dout0); end
        n_checks++; if (dout2 !== 32'h00AD00EF) begin n_fail++; $display("FAIL lane_merge_d2: got %h expected 00ad00ef", dout2); end
        @(negedge clock);
        n_checks++; if (dout1 !== 32'h00AD00EF) begin n_fail++; $display("FAIL lane_merge_d1: got %h expected 00ad00ef", dout1); end
        $display("read-during-write: d0 %h d1 %h d2 %h", dout0, dout1, dout2);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_v [3];
        exp_v[0] = 32'h11111111; exp_v[1] = 32'h22222222; exp_v[2] = 32'h33333333;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            en_a = 1'b1; write_en_a = 4'b1111; addr_a = 4'(i); data_in_a = exp_v[i];
        end
        @(negedge clock);
        en_a = 1'b0; en_b = 1'b1; addr_b = 4'd0;
        @(negedge clock);
        n_checks++; if (valid1 !== 1'b0) begin n_fail++; $display("FAIL b2b_latency_d1: got valid %b expected 0", valid1); end
        n_checks++; if (dout0 !== exp_v[0] || valid0 !== 1'b1) begin n_fail++; $display("FAIL b2b_d0: got %h/%b expected %h/1", dout0, valid0, exp_v[0]); end
        addr_b = 4'd1;
        @(negedge clock);
        addr_b = 4'd2;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (dout1 !== exp_v[i] || valid1 !== 1'b1) begin n_fail++; $display("FAIL b2b_d1 read %0d: got %h/%b expected %h/1", i, dout1, valid1, exp_v[i]); end
            $display("back-to-back read %0d -> %h valid %b", i, dout1, valid1);
            @(negedge clock);
            en_b = 1'b0;
        end
        n_checks++; if (valid1 !== 1'b0 || dout1 !== exp_v[2]) begin n_fail++; $display("FAIL b2b_hold_d1: got %h/%b expected %h/0", dout1, valid1, exp_v[2]); end
    endtask

    task automatic test_out_of_range();
        @(negedge clock);
        en_a = 1'b1; write_en_a = 4'b1111; addr_a = 4'd13; data_in_a = 32'hCAFEF00D;
        @(negedge clock);
        en_a = 1'b0; en_b = 1'b1; addr_b = 4'd13;
        @(negedge clock);
        n_checks++; if (dout2 !== 32'h0 || valid2 !== 1'b1) begin n_fail++; $display("FAIL oor_read_d2: got %h/%b expected 00000000/1", dout2, valid2); end
        n_checks++; if (dout0 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL in_range_13_d0: got %h expected cafef00d", dout0); end
        addr_b = 4'd5;
        @(negedge clock);
        n_checks++; if (dout2 !== 32'h12345678) begin n_fail++; $display("FAIL oor_no_alias5_d2: got %h expected 12345678", dout2); end
        addr_b = 4'd1;
        @(negedge clock);
        en_b = 1'b0;
        n_checks++; if (dout2 !== 32'h22222222) begin n_fail++; $display("FAIL oor_no_alias1_d2: got %h expected 22222222", dout2); end
        $display("out-of-range addr 13: d2 read back ok, d0 %h", dout0);
    endtask

    task automatic test_reset_restart();
        int  f0;
        logic seen_valid;
        f0 = 0; seen_valid = 1'b0;
        @(negedge clock);
        en_b = 1'b1; addr_b = 4'd2;
        @(negedge clock);
        en_b = 1'b0; reset_n = 1'b0;
        #1;
        n_checks++; if (valid1 !== 1'b0 || dout1 !== 32'h0) begin n_fail++; $display("FAIL flush_d1: got %h/%b expected 00000000/0", dout1, valid1); end
        n_checks++; if (valid0 !== 1'b0 || busy0 !== 1'b1) begin n_fail++; $display("FAIL flush_d0: got valid %b busy %b expected 0/1", valid0, busy0); end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (7) begin
            @(negedge clock);
            if (valid1) seen_valid = 1'b1;
        end
        n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL mid_clear_busy: got %b expected 1", busy0); end
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (valid1) seen_valid = 1'b1;
            if (!busy0 && f0 == 0) f0 = n;
        end
        n_checks++; if (f0 != 16) begin n_fail++; $display("FAIL restart_edges: got %0d expected 16", f0); end
        n_checks++; if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL flushed_read_valid: got %b expected 0", seen_valid); end
        en_b = 1'b1; addr_b = 4'd3;
        @(negedge clock);
        en_b = 1'b0;
        n_checks++; if (dout0 !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL recleared_d0: got %h expected a5a5a5a5", dout0); end
        @(negedge clock);
        n_checks++; if (dout1 !== 32'h0 || valid1 !== 1'b1) begin n_fail++; $display("FAIL recleared_d1: got %h/%b expected 00000000/1", dout1, valid1); end
        $display("reset restart: clear took %0d edges, addr 3 d0 %h d1 %h", f0, dout0, dout1);
    endtask

    initial begin
        test_reset();
        test_clear_reads();
        test_byte_write();
        test_rdw();
        test_back_to_back();
        test_out_of_range();
        test_reset_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
